pipe_adder: RTL and testbench

Parametrised, pipelined successor to the team's 16-bit ripple-carry adder. Adds or subtracts two WIDTH-bit operands, resolving one SEG-bit segment per pipeline stage, so the carry chain per cycle is only SEG bits. Uses a valid/ready handshake on both sides, carry-in/carry-out and a signed overflow flag. Sits as the ALU add/sub datapath behind the operand register stage.

---
 rtl/pipe_adder.sv | 138 +++++++++++++
 tb/tb_pipe_adder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined add/sub datapath that resolves one SEG-bit segment per
// stage, so each cycle only ripples a SEG-bit carry chain. There are
// NSEG = WIDTH/SEG stages, and the latency is NSEG cycles.
//
// Handshake (valid/ready, both sides):
//   A beat moves on any rising edge where valid && ready are both high.
//   The producer holds valid until that edge. The consumer may apply
//   backpressure at any time by holding out_ready low.
//   The pipeline stalls globally: advance = !out_valid || out_ready.
//   All stages shift together when advance is 1 and hold otherwise.
//   in_ready equals advance, so the input side has no skid buffering.
//   flush empties every stage and has priority over both accept and stall.
module pipe_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NSEG = WIDTH / SEG;

  // Stage registers. Stage i+1 lives at index i.
  // a_q/b_q hold the still-unresolved operand bits. They are shifted down so
  // that the next segment to resolve always sits in the low SEG bits.
  // b_q already holds the effective operand (~b when subtracting).
  // sum_q holds the resolved low segments, each at its final bit position.
  logic [NSEG-1:0]  vld_q;
  logic [NSEG-1:0]  c_q;
  logic [WIDTH-1:0] a_q   [NSEG];
  logic [WIDTH-1:0] b_q   [NSEG];
  logic [WIDTH-1:0] sum_q [NSEG];
  logic             ovf_q;

  // Per-stage inputs and computed next values.
  logic [WIDTH-1:0] src_a   [NSEG];
  logic [WIDTH-1:0] src_b   [NSEG];
  logic [WIDTH-1:0] src_sum [NSEG];
  logic [WIDTH-1:0] nxt_sum [NSEG];
  logic [NSEG-1:0]  src_c;
  logic [NSEG-1:0]  nxt_c;
  logic             nxt_ovf;

  logic advance;
  logic accept;

  assign advance  = !vld_q[NSEG-1] || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  for (genvar g = 0; g < NSEG; g++) begin : g_stage
    logic [SEG:0]     seg_w;
    logic [WIDTH-1:0] merged;

    if (g == 0) begin : g_first
      // Stage 1 takes the raw operands.
      // Subtract is computed as a + ~b + 1, so c_in is ignored.
      assign src_a[g]   = a;
      assign src_b[g]   = sub ? ~b : b;
      assign src_sum[g] = '0;
      assign src_c[g]   = sub | c_in;
    end else begin : g_next
      assign src_a[g]   = a_q[g-1];
      assign src_b[g]   = b_q[g-1];
      assign src_sum[g] = sum_q[g-1];
      assign src_c[g]   = c_q[g-1];
    end

    // One SEG-bit ripple: resolve segment g from the incoming carry.
    assign seg_w = {1'b0, src_a[g][SEG-1:0]} + {1'b0, src_b[g][SEG-1:0]}
                 + {{SEG{1'b0}}, src_c[g]};

    // Insert the resolved segment at its final position within the sum.
    always_comb begin
      merged = src_sum[g];
      merged[g*SEG +: SEG] = seg_w[SEG-1:0];
    end

    assign nxt_sum[g] = merged;
    assign nxt_c[g]   = seg_w[SEG];
  end

  // The carry into the MSB is recovered from the MSB operand and sum bits.
  // Signed overflow is that carry XOR the carry out of the MSB.
  assign nxt_ovf = src_a[NSEG-1][SEG-1] ^ src_b[NSEG-1][SEG-1]
                 ^ nxt_sum[NSEG-1][WIDTH-1] ^ nxt_c[NSEG-1];

  // Valid bits: flush clears every stage.
  // Otherwise, on advance, shift the valid bits and enter accept (or a bubble) at stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else if (advance) begin
      vld_q <= (vld_q << 1) | NSEG'(accept);
    end
  end

  // Datapath registers: all stages shift together on advance and hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NSEG; s++) begin
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sum_q[s] <= '0;
      end
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int s = 0; s < NSEG; s++) begin
        a_q[s]   <= src_a[s] >> SEG;
        b_q[s]   <= src_b[s] >> SEG;
        sum_q[s] <= nxt_sum[s];
      end
      c_q   <= nxt_c;
      ovf_q <= nxt_ovf;
    end
  end

  assign out_valid = vld_q[NSEG-1];
  assign sum       = sum_q[NSEG-1];
  assign c_out     = c_q[NSEG-1];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: covers directed add/sub vectors, stall, flush and random
// streams on a 16/4 instance, plus random streams with a mid-stream
// asynchronous reset on 32/8 and 32/32 instances.
module tb_pipe_adder;

  localparam int W  = 16;
  localparam int S  = 4;
  localparam int N  = W / S;
  localparam int W2 = 32;

  // ---------------- clock / reset / signals ----------------
  logic clk;
  logic rst_n, in_valid, in_ready, c_in, sub, flush, out_valid, out_ready, c_out, overflow;
  logic [W-1:0] a, b, sum;

  logic rst2_n, v2, c2, s2, ord2, fl2;
  logic [W2-1:0] a2, b2;
  logic rdy8, ov8, co8, of8, rdy32, ov32, co32, of32;
  logic [W2-1:0] sum8, sum32;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  bit acc8, acc32;

  logic [63:0] exp_q[$];
  logic [63:0] exp8_q[$];
  logic [63:0] exp32_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(W), .SEG(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .c_out(c_out), .overflow(overflow)
  );

  pipe_adder #(.WIDTH(W2), .SEG(8)) dut8 (
    .clk(clk), .rst_n(rst2_n), .in_valid(v2), .in_ready(rdy8),
    .a(a2), .b(b2), .c_in(c2), .sub(s2), .flush(fl2),
    .out_valid(ov8), .out_ready(ord2), .sum(sum8),
    .c_out(co8), .overflow(of8)
  );

  pipe_adder #(.WIDTH(W2), .SEG(32)) dut32 (
    .clk(clk), .rst_n(rst2_n), .in_valid(v2), .in_ready(rdy32),
    .a(a2), .b(b2), .c_in(c2), .sub(s2), .flush(fl2),
    .out_valid(ov32), .out_ready(ord2), .sum(sum32),
    .c_out(co32), .overflow(of32)
  );

  // ---------------- checking and reference model ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns {overflow, carry/no-borrow, sum} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mc, input logic ms, input int w);
    longint mask, ua, ub, sa, sb, full, sres, smax, smin;
    logic co, ov;
    mask = (longint'(1) << w) - 1;
    ua   = longint'({32'd0, ma}) & mask;
    ub   = longint'({32'd0, mb}) & mask;
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    sa   = (ua > smax) ? ua - (mask + 1) : ua;
    sb   = (ub > smax) ? ub - (mask + 1) : ub;
    if (ms) begin
      full = ua - ub;
      co   = (ua >= ub);
      sres = sa - sb;
    end else begin
      full = ua + ub + longint'(mc);
      co   = (full > mask);
      sres = sa + sb + longint'(mc);
    end
    ov = (sres > smax) || (sres < smin);
    return (64'(ov) << (w + 1)) | (64'(co) << w) | 64'(full & mask);
  endfunction

  // ---------------- scoreboards ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("main_extra", 64'(out_valid), 64'd0);
      else check("main_out", 64'({overflow, c_out, sum}), exp_q.pop_front());
      n_out++;
    end
  end

  always @(negedge clk) begin
    acc8  = rst2_n && v2 && rdy8;
    acc32 = rst2_n && v2 && rdy32;
    if (rst2_n && ov8 && ord2) begin
      if (exp8_q.size() == 0) check("s8_extra", 64'(ov8), 64'd0);
      else check("s8_out", 64'({of8, co8, sum8}), exp8_q.pop_front());
    end
    if (rst2_n && ov32 && ord2) begin
      if (exp32_q.size() == 0) check("s32_extra", 64'(ov32), 64'd0);
      else check("s32_out", 64'({of32, co32, sum32}), exp32_q.pop_front());
    end
  end

  always @(posedge clk) begin
    if (rst2_n && acc8)  exp8_q.push_back(model(a2, b2, c2, s2, W2));
    if (rst2_n && acc32) exp32_q.push_back(model(a2, b2, c2, s2, W2));
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send_exp(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic ts, input logic [63:0] e);
    logic rdy;
    bit   done;
    done     = 1'b0;
    in_valid = 1'b1;
    a = ta; b = tb; c_in = tc; sub = ts;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
    end
    #1;
    if (!done) check("send_timeout", 64'(done), 64'd1);
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
    @(posedge clk);
    #1;
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n0, l8, l32;
    logic [W-1:0] ta, tb;
    logic tc, ts;

    rst_n = 0; rst2_n = 0; in_valid = 0; a = '0; b = '0; c_in = 0; sub = 0;
    flush = 0; out_ready = 1;
    v2 = 0; a2 = '0; b2 = '0; c2 = 0; s2 = 0; ord2 = 1; fl2 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_result", 64'({overflow, c_out, sum}), 64'd0);
    check("rst_s8_valid", 64'(ov8), 64'd0);
    check("rst_s32_valid", 64'(ov32), 64'd0);
    rst_n = 1; rst2_n = 1;

    // Basic add and latency.
    send_exp(16'h00FF, 16'h0001, 1'b0, 1'b0, 64'h00100);
    in_valid = 0;
    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      check("latency", 64'(out_valid), 64'(c == N - 1));
    end
    @(posedge clk); #1;

    // Carry through all segments, signed overflow, subtract.
    send_exp(16'hFFFF, 16'h0000, 1'b1, 1'b0, 64'h10000);
    send_exp(16'h7FFF, 16'h0001, 1'b0, 1'b0, 64'h28000);
    send_exp(16'h0005, 16'h0007, 1'b1, 1'b1, 64'h0FFFE);
    send_exp(16'h8000, 16'h0001, 1'b0, 1'b1, 64'h37FFF);
    in_valid = 0;
    drain("drain_arith");

    // Back-to-back stream with a 3-cycle consumer stall.
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send_exp(16'(i), 16'(3 * i), 1'b0, 1'b0, 64'(4 * i));
        in_valid = 0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("stall_in_ready", 64'(in_ready), 64'd0);
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_hold", 64'({overflow, c_out, sum}), 64'd8);
        end
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain("drain_stall");
    check("stall_count", 64'(n_out - n0), 64'd8);

    // Flush with three beats in flight.
    send_exp(16'h1111, 16'h0001, 1'b0, 1'b0, 64'h01112);
    send_exp(16'h2222, 16'h0002, 1'b0, 1'b0, 64'h02224);
    send_exp(16'h3333, 16'h0003, 1'b0, 1'b0, 64'h03336);
    in_valid = 0;
    flush = 1;
    @(posedge clk);
    exp_q.delete();
    #1 flush = 0;
    n0 = n_out;
    @(negedge clk);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);
    repeat (6) @(negedge clk);
    check("flush_gone", 64'(n_out - n0), 64'd0);
    @(posedge clk); #1;
    send_exp(16'h1234, 16'h1111, 1'b0, 1'b0, 64'h02345);
    in_valid = 0;
    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      check("post_flush_lat", 64'(out_valid), 64'(c == N - 1));
    end
    @(posedge clk); #1;
    drain("drain_flush");

    // Random stream with random backpressure.
    fork
      begin
        repeat (40) begin
          ta = 16'($urandom); tb = 16'($urandom);
          tc = 1'($urandom); ts = 1'($urandom);
          send_exp(ta, tb, tc, ts, model(32'(ta), 32'(tb), tc, ts, W));
        end
        in_valid = 0;
      end
      begin
        repeat (60) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1;
      end
    join
    drain("drain_random");

    // 32-bit instances: latency of a single beat.
    v2 = 1; a2 = $urandom; b2 = $urandom; c2 = 1'($urandom); s2 = 1'($urandom);
    @(posedge clk); #1;
    v2 = 0;
    l8 = 0; l32 = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (ov8 && l8 == 0) l8 = c;
      if (ov32 && l32 == 0) l32 = c;
    end
    check("lat_s8", 64'(l8), 64'd4);
    check("lat_s32", 64'(l32), 64'd1);
    @(posedge clk); #1;

    // 32-bit random stream with an asynchronous reset pulse mid-stream.
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc == 100) begin
        #2 rst2_n = 0;
        #1;
        check("arst_s8_valid", 64'(ov8), 64'd0);
        check("arst_s32_valid", 64'(ov32), 64'd0);
        check("arst_s8_sum", 64'(sum8), 64'd0);
        exp8_q.delete();
        exp32_q.delete();
        @(posedge clk);
        #1 rst2_n = 1;
      end
      v2   = ($urandom_range(0, 3) != 0);
      a2   = $urandom; b2 = $urandom;
      c2   = 1'($urandom); s2 = 1'($urandom);
      ord2 = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    v2 = 0; ord2 = 1;
    for (int t = 0; t < 100 && (exp8_q.size() != 0 || exp32_q.size() != 0); t++)
      @(posedge clk);
    @(posedge clk); #1;
    check("drain_s8", 64'(exp8_q.size()), 64'd0);
    check("drain_s32", 64'(exp32_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
